apb3_master_arbiter: RTL and testbench
======================================

Name: apb3_master_arbiter

Overview:
- Round-robin arbiter and APB3 master sequencer; shares one APB3 bus between NR_OF_REQUESTERS_P requesters.
- Each requester uses a simple valid/ready request channel and receives a one-cycle response pulse.
- Decodes the slave from the upper address bits, drives psel/penable through SETUP/ACCESS, and returns prdata/pslverr.
- Aborts stuck transfers with a timeout; sits between bus-master clients (CPU bridge, DMA, test masters) and the APB3 slave fabric.

Parameters:
- NR_OF_REQUESTERS_P, 2, number of requesters (≥1).
- APB_ADDR_WIDTH_P, 16, paddr width.
- APB_DATA_WIDTH_P, 32, pwdata/prdata width.
- APB_NR_OF_SLAVES_P, 4, number of psel/pready lines (≥1).
- SLAVE_SEL_WIDTH_P, 2, number of paddr MSBs used as slave index; 2^SLAVE_SEL_WIDTH_P ≥ APB_NR_OF_SLAVES_P.
- TIMEOUT_P, 255, maximum ACCESS cycles without pready before abort (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NR_OF_REQUESTERS_P  request pending, one bit per requester.
- req_ready  out  NR_OF_REQUESTERS_P  request accepted, one-hot.
- req_write  in  NR_OF_REQUESTERS_P  1 = write, 0 = read.
- req_addr  in  NR_OF_REQUESTERS_P*APB_ADDR_WIDTH_P  flattened addresses; requester i at slice i.
- req_wdata  in  NR_OF_REQUESTERS_P*APB_DATA_WIDTH_P  flattened write data.
- rsp_valid  out  NR_OF_REQUESTERS_P  one-cycle response pulse, one-hot.
- rsp_rdata  out  APB_DATA_WIDTH_P  read data; valid with rsp_valid.
- rsp_slverr  out  1  error: pslverr, decode error or timeout.
- rsp_timeout  out  1  error cause was timeout.
- paddr  out  APB_ADDR_WIDTH_P  APB address.
- psel  out  APB_NR_OF_SLAVES_P  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  APB_DATA_WIDTH_P  APB write data.
- pready  in  APB_NR_OF_SLAVES_P  per-slave ready.
- prdata  in  APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P  per-slave read data; slave s at slice s.
- pslverr  in  1  shared slave error.

Behaviour:
- Reset: rst sampled high on a clk edge → all outputs 0, FSM = IDLE, round-robin pointer = 0, timeout counter = 0. A reset mid-transfer drops psel/penable at that edge, emits no response, and discards the latched request.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching upward from the pointer, with wrap-around.
  - req_ready[winner] = 1 combinationally in that cycle.
  - At the edge, latch addr/wdata/write/winner, set pointer = (winner+1) mod N, and go to SETUP.
  - A requester must hold its request stable until req_ready.
- SETUP (1 cycle):
  - Slave index = paddr[APB_ADDR_WIDTH_P-1 -: SLAVE_SEL_WIDTH_P].
  - Index < APB_NR_OF_SLAVES_P: psel[index] = 1, penable = 0, and paddr/pwrite/pwdata are driven from the latch → ACCESS.
  - Index ≥ APB_NR_OF_SLAVES_P (decode error): psel stays 0, no bus activity → RESP with rsp_slverr = 1, rsp_rdata = 0.
- ACCESS:
  - psel held, penable = 1, counter increments each cycle.
  - pready[index] = 1: capture prdata slice[index] (reads only; writes return 0) and pslverr, then go to RESP. psel and penable drop at that edge.
  - Counter reaches TIMEOUT_P with pready low: go to RESP with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0; psel and penable drop.
  - pready lines of unselected slaves are ignored.
- RESP (1 cycle): rsp_valid[winner] = 1 with rsp_rdata, rsp_slverr and rsp_timeout registered; counter cleared → IDLE.
- paddr, pwrite and pwdata hold their values outside a transfer; psel and penable are 0 outside SETUP/ACCESS.
- Latency: req_ready to rsp_valid = 3 + wait-state cycles.
- Minimum period per transfer is 4 cycles (IDLE grant, SETUP, ACCESS, RESP); back-to-back grants are possible from the IDLE following RESP.
- Simultaneous requests are served fairly: each requester waits at most N-1 transfers. A requester dropping req_valid before it is granted is simply skipped.
- With N = 1 the pointer is constant 0.

Test Plan:
- Single write, requester 0, addr 0x4010, wdata 0xDEADBEEF, slave 1 with pready tied high → psel = 0b0010 in SETUP, penable in ACCESS for 1 cycle, rsp_valid = 0b01 exactly 3 cycles after req_ready, rsp_slverr = 0.
- Read with 3 wait states from slave 2, prdata slice = 0x12345678 → ACCESS lasts 4 cycles, rsp_rdata = 0x12345678, rsp_valid = 1 cycle.
- Both requesters hold req_valid continuously for 4 transfers starting from reset → grants alternate 0,1,0,1; every req_ready and rsp_valid is one-hot.
- APB_NR_OF_SLAVES_P = 3, addr 0xC000 (index 3) → psel never set, rsp_slverr = 1, rsp_rdata = 0, rsp_timeout = 0.
- TIMEOUT_P = 8, slave never asserts pready → penable high for 8 cycles, then psel/penable = 0, rsp_slverr = 1, rsp_timeout = 1; the next request completes normally.
- rst asserted for one cycle during ACCESS → outputs 0 at the next edge, no rsp_valid pulse; a pending requester 1 gets req_ready in the first IDLE cycle after rst deasserts, with the pointer at 0.

Source files
------------

// File: rtl/apb3_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb3_master_arbiter
//   Round-robin arbiter in front of an APB3 master sequencer. Several
//   requesters share one APB3 bus; each winner's transfer runs through
//   SETUP and ACCESS, and a one-cycle response pulse returns the read data and
//   the error status. ACCESS phases that never see pready are aborted after
//   TIMEOUT_P cycles.
//
// Request handshake: a requester raises req_valid[i] with req_write/req_addr/
//   req_wdata stable. The request is accepted on the rising clk edge where
//   req_valid[i] and req_ready[i] are both high. req_ready is combinational,
//   one-hot, high only in IDLE and never while rst is high. The requester
//   must hold its request unchanged until accepted. Exactly one rsp_valid
//   pulse follows each accepted request, unless rst intervenes.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/ready/write     per-requester request channel
//   req_addr, req_wdata       flattened per-requester address / write data
//   rsp_valid                 one-hot, one-cycle response pulse
//   rsp_rdata/slverr/timeout  response payload, valid with rsp_valid
//   paddr..pwdata, psel       APB3 master outputs (psel one-hot per slave)
//   pready, prdata, pslverr   APB3 slave returns (pready/prdata per slave)
// -----------------------------------------------------------------------------
module apb3_master_arbiter #(
  parameter int NR_OF_REQUESTERS_P = 2,
  parameter int APB_ADDR_WIDTH_P   = 16,
  parameter int APB_DATA_WIDTH_P   = 32,
  parameter int APB_NR_OF_SLAVES_P = 4,
  parameter int SLAVE_SEL_WIDTH_P  = 2,
  parameter int TIMEOUT_P          = 255
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NR_OF_REQUESTERS_P-1:0]                  req_valid,
  output logic [NR_OF_REQUESTERS_P-1:0]                  req_ready,
  input  logic [NR_OF_REQUESTERS_P-1:0]                  req_write,
  input  logic [NR_OF_REQUESTERS_P*APB_ADDR_WIDTH_P-1:0] req_addr,
  input  logic [NR_OF_REQUESTERS_P*APB_DATA_WIDTH_P-1:0] req_wdata,
  output logic [NR_OF_REQUESTERS_P-1:0]                  rsp_valid,
  output logic [APB_DATA_WIDTH_P-1:0]                    rsp_rdata,
  output logic                                           rsp_slverr,
  output logic                                           rsp_timeout,
  output logic [APB_ADDR_WIDTH_P-1:0]                    paddr,
  output logic [APB_NR_OF_SLAVES_P-1:0]                  psel,
  output logic                                           penable,
  output logic                                           pwrite,
  output logic [APB_DATA_WIDTH_P-1:0]                    pwdata,
  input  logic [APB_NR_OF_SLAVES_P-1:0]                  pready,
  input  logic [APB_NR_OF_SLAVES_P*APB_DATA_WIDTH_P-1:0] prdata,
  input  logic                                           pslverr
);

  localparam int N     = NR_OF_REQUESTERS_P;
  localparam int AW    = APB_ADDR_WIDTH_P;
  localparam int DW    = APB_DATA_WIDTH_P;
  localparam int NS    = APB_NR_OF_SLAVES_P;
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_P + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic                   slverr_q, slverr_d;
  logic                   timeout_q, timeout_d;

  // Arbitration results
  logic                   found;
  logic [PTR_W-1:0]       win;
  logic [PTR_W-1:0]       ptr_next;
  logic [AW-1:0]          pick_addr;
  logic [DW-1:0]          pick_wdata;
  logic                   pick_write;

  // Slave decode results
  logic [SLAVE_SEL_WIDTH_P-1:0] slave_idx;
  logic                   decode_ok;
  logic                   sel_ready;
  logic [DW-1:0]          sel_rdata;

  // Round-robin search: first pass covers requesters at or above the
  // pointer, second pass wraps around to the ones below it.
  always_comb begin
    found      = 1'b0;
    win        = '0;
    ptr_next   = '0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_write = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_valid[i] && (i >= int'(ptr_q))) begin
        found      = 1'b1;
        win        = PTR_W'(i);
        ptr_next   = (i == N - 1) ? '0 : PTR_W'(i + 1);
        pick_addr  = req_addr[i*AW +: AW];
        pick_wdata = req_wdata[i*DW +: DW];
        pick_write = req_write[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_valid[i]) begin
        found      = 1'b1;
        win        = PTR_W'(i);
        ptr_next   = (i == N - 1) ? '0 : PTR_W'(i + 1);
        pick_addr  = req_addr[i*AW +: AW];
        pick_wdata = req_wdata[i*DW +: DW];
        pick_write = req_write[i];
      end
    end
  end

  // Slave decode from the latched address MSBs; indices beyond the last
  // slave are decode errors and never reach the bus.
  assign slave_idx = addr_q[AW-1 -: SLAVE_SEL_WIDTH_P];
  assign decode_ok = int'(slave_idx) < NS;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int s = 0; s < NS; s++) begin
      if (int'(slave_idx) == s) begin
        sel_ready = pready[s];
        sel_rdata = prdata[s*DW +: DW];
      end
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = win;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          write_d = pick_write;
          ptr_d   = ptr_next;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (decode_ok) begin
          state_d = ACCESS;
        end else begin
          rdata_d   = '0;
          slverr_d  = 1'b1;
          timeout_d = 1'b0;
          state_d   = RESP;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sel_ready) begin
          // Writes return zero data even if the slave drives prdata.
          rdata_d   = write_q ? '0 : sel_rdata;
          slverr_d  = pslverr;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_P - 1)) begin
          // This is the TIMEOUT_P-th ACCESS cycle without pready.
          rdata_d   = '0;
          slverr_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs. The address/data latch doubles as the bus drivers so they
  // hold between transfers; psel/penable only live in SETUP/ACCESS.
  assign paddr   = addr_q;
  assign pwdata  = wdata_q;
  assign pwrite  = write_q;
  assign penable = (state_q == ACCESS);

  always_comb begin
    psel = '0;
    for (int s = 0; s < NS; s++) begin
      psel[s] = ((state_q == SETUP) || (state_q == ACCESS)) && decode_ok &&
                (int'(slave_idx) == s);
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = (state_q == IDLE) && !rst && found && (int'(win) == i);
      rsp_valid[i] = (state_q == RESP) && (int'(owner_q) == i);
    end
  end

  assign rsp_rdata   = (state_q == RESP) ? rdata_q : '0;
  assign rsp_slverr  = (state_q == RESP) && slverr_q;
  assign rsp_timeout = (state_q == RESP) && timeout_q;

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb3_master_arbiter
//   Directed bench for apb3_master_arbiter configured with 2 requesters,
//   3 slaves and an 8-cycle timeout. A behavioural APB slave model answers
//   with per-slave wait states; unselected slaves hold pready high so that
//   stray pready lines are exercised. Each expected response (bus phase
//   observations plus response payload) is queued when its request is issued
//   and popped by the monitor on every rsp_valid pulse.
// -----------------------------------------------------------------------------
module tb_apb3_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int TO = 8;
  // {psel@SETUP(3), penable cycles(8), latency(8), rsp_valid(2), rdata(32),
  //  slverr, timeout, paddr@SETUP(16), pwdata@SETUP(32), pwrite@SETUP}
  localparam int W  = 104;

  logic                clk;
  logic                rst;
  logic [NR-1:0]       req_valid;
  logic [NR-1:0]       req_ready;
  logic [NR-1:0]       req_write;
  logic [NR*AW-1:0]    req_addr;
  logic [NR*DW-1:0]    req_wdata;
  logic [NR-1:0]       rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_slverr;
  logic                rsp_timeout;
  logic [AW-1:0]       paddr;
  logic [NS-1:0]       psel;
  logic                penable;
  logic                pwrite;
  logic [DW-1:0]       pwdata;
  logic [NS-1:0]       pready;
  logic [NS*DW-1:0]    prdata;
  logic                pslverr;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  apb3_master_arbiter #(
    .NR_OF_REQUESTERS_P (NR),
    .APB_ADDR_WIDTH_P   (AW),
    .APB_DATA_WIDTH_P   (DW),
    .APB_NR_OF_SLAVES_P (NS),
    .SLAVE_SEL_WIDTH_P  (SW),
    .TIMEOUT_P          (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- APB slave model ----------------
  int   wait_cfg [NS];
  int   acc_cnt  [NS];
  logic err_en;

  assign prdata = {32'h12345678, 32'hB1B10002, 32'hA0A00001};

  initial begin
    pready  = '0;
    pslverr = 1'b0;
    for (int s = 0; s < NS; s++) acc_cnt[s] = 0;
  end

  always @(negedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (psel[s] && penable) begin
        pready[s]  = (acc_cnt[s] >= wait_cfg[s]);
        acc_cnt[s] = acc_cnt[s] + 1;
      end else if (psel[s]) begin
        pready[s]  = 1'b0;
        acc_cnt[s] = 0;
      end else begin
        pready[s]  = 1'b1;
        acc_cnt[s] = 0;
      end
    end
    pslverr = err_en && penable;
  end

  // ---------------- scoreboard monitor ----------------
  logic [NS-1:0] cap_psel;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic          cap_wr;
  logic [7:0]    en_cnt;
  logic [7:0]    lat;

  function automatic logic [W-1:0] pk(input logic [NS-1:0] ps, input logic [7:0] en,
                                      input logic [7:0] lt, input logic [NR-1:0] v,
                                      input logic [DW-1:0] rd, input logic er,
                                      input logic tm, input logic [AW-1:0] a,
                                      input logic [DW-1:0] wd, input logic wr);
    return {ps, en, lt, v, rd, er, tm, a, wd, wr};
  endfunction

  initial begin
    cap_psel = '0; cap_addr = '0; cap_wdata = '0; cap_wr = 1'b0;
    en_cnt = '0; lat = '0;
  end

  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    if (rst) begin
      cap_psel = '0; cap_addr = '0; cap_wdata = '0; cap_wr = 1'b0;
      en_cnt = '0; lat = '0;
    end else begin
      lat = lat + 8'd1;
      if (req_ready != '0) begin
        lat = '0;
        total++;
        if ($countones(req_ready) != 1) begin
          bad++;
          $display("FAIL req_ready_onehot got=%b", req_ready);
        end
      end
      if (psel != '0 && !penable) begin
        cap_psel = psel; cap_addr = paddr; cap_wdata = pwdata; cap_wr = pwrite;
      end
      if (penable) en_cnt = en_cnt + 8'd1;
      if (rsp_valid != '0) begin
        got = pk(cap_psel, en_cnt, lat, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
                 cap_addr, cap_wdata, cap_wr);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got=%h", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL rsp got=%h exp=%h", got, e);
          end
        end
        cap_psel = '0; cap_addr = '0; cap_wdata = '0; cap_wr = 1'b0; en_cnt = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    req_valid[i]          = 1'b1;
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = wd;
  endtask

  // Raise one request and hold it until accepted.
  task automatic do_req(input int i, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    set_req(i, wr, a, wd);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL grant_wait req=%0d got=none exp=req_ready", i);
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int grants;
    logic [NR-1:0] exp_g;
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    err_en = 1'b0;
    wait_cfg[0] = 0; wait_cfg[1] = 0; wait_cfg[2] = 3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write to slave 1, zero wait states
    exp_q.push_back(pk(3'b010, 8'd1, 8'd3, 2'b01, 32'h0, 1'b0, 1'b0,
                       16'h4010, 32'hDEADBEEF, 1'b1));
    do_req(0, 1'b1, 16'h4010, 32'hDEADBEEF);
    drain();

    // Read slave 2 with three wait states
    exp_q.push_back(pk(3'b100, 8'd4, 8'd6, 2'b10, 32'h12345678, 1'b0, 1'b0,
                       16'h8004, 32'h00000055, 1'b0));
    do_req(1, 1'b0, 16'h8004, 32'h00000055);
    drain();

    // Read slave 0 with pslverr: data still captured
    err_en = 1'b1;
    exp_q.push_back(pk(3'b001, 8'd1, 8'd3, 2'b01, 32'hA0A00001, 1'b1, 1'b0,
                       16'h0020, 32'h0, 1'b0));
    do_req(0, 1'b0, 16'h0020, 32'h0);
    drain();
    err_en = 1'b0;

    // Write to slave 2: returns zero data
    exp_q.push_back(pk(3'b100, 8'd4, 8'd6, 2'b10, 32'h0, 1'b0, 1'b0,
                       16'h8100, 32'hCAFEF00D, 1'b1));
    do_req(1, 1'b1, 16'h8100, 32'hCAFEF00D);
    drain();

    // Both requesters hold requests from reset: grants 0,1,0,1
    do_reset();
    exp_q.push_back(pk(3'b001, 8'd1, 8'd3, 2'b01, 32'hA0A00001, 1'b0, 1'b0, 16'h0100, 32'h0, 1'b0));
    exp_q.push_back(pk(3'b010, 8'd1, 8'd3, 2'b10, 32'hB1B10002, 1'b0, 1'b0, 16'h4200, 32'h0, 1'b0));
    exp_q.push_back(pk(3'b001, 8'd1, 8'd3, 2'b01, 32'hA0A00001, 1'b0, 1'b0, 16'h0100, 32'h0, 1'b0));
    exp_q.push_back(pk(3'b010, 8'd1, 8'd3, 2'b10, 32'hB1B10002, 1'b0, 1'b0, 16'h4200, 32'h0, 1'b0));
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0100, 32'h0);
    set_req(1, 1'b0, 16'h4200, 32'h0);
    grants = 0;
    exp_g  = 2'b01;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("rr_grant", 64'(req_ready), 64'(exp_g));
        exp_g  = ~exp_g;
        grants = grants + 1;
        if (grants == 4) break;
      end
    end
    chk("rr_grant_count", 64'(grants), 64'd4);
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Decode error: index 3 with three slaves
    exp_q.push_back(pk(3'b000, 8'd0, 8'd2, 2'b01, 32'h0, 1'b1, 1'b0,
                       16'h0000, 32'h0, 1'b0));
    do_req(0, 1'b0, 16'hC000, 32'h0);
    drain();

    // Timeout on a slave that never answers, then a normal transfer
    wait_cfg[1] = 1000;
    exp_q.push_back(pk(3'b010, 8'd8, 8'd10, 2'b10, 32'h0, 1'b1, 1'b1,
                       16'h4000, 32'h0, 1'b0));
    do_req(1, 1'b0, 16'h4000, 32'h0);
    drain();
    wait_cfg[1] = 0;
    exp_q.push_back(pk(3'b010, 8'd1, 8'd3, 2'b10, 32'hB1B10002, 1'b0, 1'b0,
                       16'h4004, 32'h0, 1'b0));
    do_req(1, 1'b0, 16'h4004, 32'h0);
    drain();

    // Reset during ACCESS with requester 1 pending
    wait_cfg[2] = 5;
    do_req(0, 1'b0, 16'h8008, 32'h0);
    @(posedge clk); #1;
    chk("pre_rst_penable", 64'(penable), 64'd1);
    exp_q.push_back(pk(3'b010, 8'd1, 8'd3, 2'b10, 32'hB1B10002, 1'b0, 1'b0,
                       16'h4008, 32'h0, 1'b0));
    rst = 1'b1;
    set_req(1, 1'b0, 16'h4008, 32'h0);
    @(negedge clk);
    chk("rst_hi_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_psel", 64'(psel), 64'd0);
    chk("mid_rst_penable", 64'(penable), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_paddr", 64'(paddr), 64'd0);
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'b10);
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    wait_cfg[2] = 3;

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
